conv_ctrl: RTL and testbench

CONV_CTRL -- requirements
Module: conv_ctrl

---
 rtl/conv_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_conv_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl.sv
// Convolution layer sequencer. It walks passes, tiles and taps, drives the BRAM and MAC controls,
// and rounds, saturates and optionally rectifies the accumulators into output words.
module conv_ctrl #(
  parameter int unsigned TAPS     = 25,
  parameter int unsigned PASSES   = 3,
  parameter int unsigned ROWS     = 28,
  parameter int unsigned ROW_STEP = 4,
  parameter int unsigned LANES    = 56,
  parameter int unsigned ACC_W    = 17,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned WADDR_W  = 12,
  parameter int unsigned FADDR_W  = 5,
  parameter int unsigned BADDR_W  = 7,
  parameter int unsigned OADDR_W  = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stall,
  input  logic                       relu_en,
  input  logic [2*LANES*ACC_W-1:0]   acc_data,
  output logic                       busy,
  output logic                       done,
  output logic                       w_en,
  output logic [WADDR_W-1:0]         w_addr,
  output logic                       fm_en,
  output logic [FADDR_W-1:0]         fm_addr,
  output logic                       bias_en,
  output logic [BADDR_W-1:0]         bias_addr,
  output logic                       acc_clr,
  output logic                       acc_en,
  output logic                       out_we,
  output logic [OADDR_W-1:0]         out_addr,
  output logic [LANES*OUT_W-1:0]     out_din
);

  localparam int unsigned NT     = ROWS / ROW_STEP;
  localparam int unsigned TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned LAT_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned TILE_W = (NT > 1) ? $clog2(NT) : 1;
  localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [TAP_W-1:0]  TapLast  = TAP_W'(TAPS - 1);
  localparam logic [LAT_W-1:0]  LatLast  = LAT_W'(PIPE_LAT - 1);
  localparam logic [TILE_W-1:0] TileLast = TILE_W'(NT - 1);
  localparam logic [PASS_W-1:0] PassLast = PASS_W'(PASSES - 1);

  if ((ROWS % ROW_STEP) != 0) begin : g_bad_rows
    $error("conv_ctrl: ROWS must be a multiple of ROW_STEP");
  end
  if (ACC_W != OUT_W + 1) begin : g_bad_acc_w
    $error("conv_ctrl: ACC_W must equal OUT_W + 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StDrain,
    StStore,
    StDone
  } state_e;

  state_e              state_q;
  logic [TAP_W-1:0]    tap_q;
  logic [LAT_W-1:0]    lat_q;
  logic                beat_q;
  logic [TILE_W-1:0]   tile_q;
  logic [PASS_W-1:0]   pass_q;

  logic [LANES*ACC_W-1:0] half_sel;
  logic [LANES*OUT_W-1:0] conv;
  logic [ACC_W-1:0]       lane_a;
  logic [ACC_W-1:0]       lane_s;
  logic [OUT_W-1:0]       lane_r;

  // Round half up by adding the dropped LSB; only the positive end can overflow.
  always_comb begin
    half_sel = beat_q ? acc_data[2*LANES*ACC_W-1:LANES*ACC_W] : acc_data[LANES*ACC_W-1:0];
    conv     = '0;
    lane_a   = '0;
    lane_s   = '0;
    lane_r   = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_a = half_sel[l*ACC_W +: ACC_W];
      lane_s = {lane_a[ACC_W-1], lane_a[ACC_W-1:1]} + {{(ACC_W-1){1'b0}}, lane_a[0]};
      if (relu_en && lane_s[OUT_W]) begin
        lane_r = '0;
      end else if (!lane_s[OUT_W] && lane_s[OUT_W-1]) begin
        lane_r = {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        lane_r = lane_s[OUT_W-1:0];
      end
      conv[l*OUT_W +: OUT_W] = lane_r;
    end
  end

  // Every action is registered at the edge that consumes its state, so all outputs are flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      tap_q     <= '0;
      lat_q     <= '0;
      beat_q    <= 1'b0;
      tile_q    <= '0;
      pass_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      fm_en     <= 1'b0;
      fm_addr   <= '0;
      bias_en   <= 1'b0;
      bias_addr <= '0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      out_din   <= '0;
    end else begin
      w_en    <= 1'b0;
      fm_en   <= 1'b0;
      bias_en <= 1'b0;
      acc_clr <= 1'b0;
      acc_en  <= 1'b0;
      out_we  <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StMac;
            tap_q   <= '0;
            lat_q   <= '0;
            beat_q  <= 1'b0;
            tile_q  <= '0;
            pass_q  <= '0;
            busy    <= 1'b1;
          end
        end
        StMac: begin
          // Address tracks the pending tap even while stalled.
          w_addr <= WADDR_W'(pass_q) * WADDR_W'(TAPS) + WADDR_W'(tap_q);
          if (!stall) begin
            w_en   <= 1'b1;
            acc_en <= 1'b1;
            if (tap_q == '0) begin
              acc_clr   <= 1'b1;
              fm_en     <= 1'b1;
              fm_addr   <= FADDR_W'(tile_q);
              bias_en   <= 1'b1;
              bias_addr <= BADDR_W'(pass_q);
            end
            if (tap_q == TapLast) begin
              tap_q   <= '0;
              state_q <= StDrain;
            end else begin
              tap_q <= tap_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (!stall) begin
            if (lat_q == LatLast) begin
              lat_q   <= '0;
              state_q <= StStore;
            end else begin
              lat_q <= lat_q + 1'b1;
            end
          end
        end
        StStore: begin
          if (!stall) begin
            out_we   <= 1'b1;
            out_addr <= OADDR_W'({pass_q, beat_q}) * OADDR_W'(NT) + OADDR_W'(tile_q);
            out_din  <= conv;
            if (!beat_q) begin
              beat_q <= 1'b1;
            end else begin
              beat_q <= 1'b0;
              if (tile_q != TileLast) begin
                tile_q  <= tile_q + 1'b1;
                state_q <= StMac;
              end else begin
                tile_q <= '0;
                if (pass_q != PassLast) begin
                  pass_q  <= pass_q + 1'b1;
                  state_q <= StMac;
                end else begin
                  state_q <= StDone;
                  done    <= 1'b1;
                end
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl: conversion table, full layers, stall, abort, held start,
// and a reduced-parameter instance.
module tb_conv_ctrl;

  localparam int LANES = 56;
  localparam int DW    = 2 * LANES * 17;
  localparam int OW    = LANES * 16;

  typedef struct packed {
    logic [16:0] a;
    logic [15:0] e_raw;
    logic [15:0] e_relu;
  } conv_vec_t;

  conv_vec_t tbl [16];

  logic          clk, rst, start, stall, relu_en;
  logic [DW-1:0] acc_data;
  logic          busy, done, w_en, fm_en, bias_en, acc_clr, acc_en, out_we;
  logic [11:0]   w_addr;
  logic [4:0]    fm_addr;
  logic [6:0]    bias_addr, out_addr;
  logic [OW-1:0] out_din;

  logic          rst2, start2, stall2;
  logic          s_busy, s_done, s_w_en, s_fm_en, s_bias_en, s_acc_clr, s_acc_en, s_out_we;
  logic [11:0]   s_w_addr;
  logic [4:0]    s_fm_addr;
  logic [6:0]    s_bias_addr, s_out_addr;
  logic [OW-1:0] s_out_din;

  int n_vec = 0;
  int n_err = 0;

  conv_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .relu_en(relu_en),
    .acc_data(acc_data), .busy(busy), .done(done), .w_en(w_en), .w_addr(w_addr),
    .fm_en(fm_en), .fm_addr(fm_addr), .bias_en(bias_en), .bias_addr(bias_addr),
    .acc_clr(acc_clr), .acc_en(acc_en), .out_we(out_we), .out_addr(out_addr),
    .out_din(out_din)
  );

  conv_ctrl #(.TAPS(9), .PASSES(1), .ROWS(8), .ROW_STEP(2), .PIPE_LAT(2)) u_small (
    .clk(clk), .rst(rst2), .start(start2), .stall(stall2), .relu_en(relu_en),
    .acc_data(acc_data), .busy(s_busy), .done(s_done), .w_en(s_w_en), .w_addr(s_w_addr),
    .fm_en(s_fm_en), .fm_addr(s_fm_addr), .bias_en(s_bias_en), .bias_addr(s_bias_addr),
    .acc_clr(s_acc_clr), .acc_en(s_acc_en), .out_we(s_out_we), .out_addr(s_out_addr),
    .out_din(s_out_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] exp_word(input bit relu, input int b);
    logic [OW-1:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++) begin
      w[l*16 +: 16] = relu ? tbl[(l + 7*b) % 16].e_relu : tbl[(l + 7*b) % 16].e_raw;
    end
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One default-size layer; the monitor carries its own model of the tap/tile/pass walk.
  task automatic run_layer(input bit relu, input bit do_stall, input bit hold_start,
                           input int exp_lat);
    int cyc = 0, busy_cyc = -1, done_cyc = -1, n_w = 0, n_wr = 0, gaps = 0, stall_left = 0;
    int p, t, k, b;
    bit seen_t3 = 0, stalled = 0;
    relu_en = relu;
    start = 1'b1;
    while (done_cyc < 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = 1'b0;
      if (busy && busy_cyc < 0) busy_cyc = cyc;
      if (busy_cyc >= 0 && !busy) gaps++;
      if (w_en) begin
        p = n_w / 175; t = (n_w % 175) / 25; k = n_w % 25;
        check("mac_ctrl", {w_addr, acc_en, acc_clr, fm_en, bias_en, fm_addr, bias_addr},
              {12'(p*25 + k), 1'b1, (k == 0), (k == 0), (k == 0), 5'(t), 7'(p)});
        if (fm_en && fm_addr == 5'd3 && bias_addr == 7'd1) seen_t3 = 1;
        n_w++;
      end
      if (out_we) begin
        p = n_wr / 14; t = (n_wr % 14) / 2; b = n_wr % 2;
        check("out_addr", out_addr, 7'((p*2 + b)*7 + t));
        check("out_din", out_din, exp_word(relu, b));
        n_wr++;
      end
      if (stall_left > 0) begin
        check("stall_hold", {w_en, acc_en, fm_en, bias_en, acc_clr, w_addr}, {5'b0, 12'd37});
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end else if (do_stall && !stalled && seen_t3 && w_en && w_addr == 12'd36) begin
        stall = 1'b1;
        stall_left = 10;
        stalled = 1;
      end
      if (done) done_cyc = cyc;
    end
    stall = 1'b0;
    check("done_seen", (done_cyc >= 0), 1'b1);
    check("latency", done_cyc - busy_cyc, exp_lat);
    check("write_count", n_wr, 42);
    check("w_en_count", n_w, 525);
    check("busy_gaps", gaps, 0);
    if (do_stall) check("stall_applied", stalled, 1'b1);
  endtask

  task automatic abort_test();
    int cyc = 0, wr = 0, bz = 0;
    bit found = 0, got = 0;
    relu_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!found && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (fm_en && fm_addr == 5'd5 && bias_addr == 7'd0) found = 1;
    end
    check("tile5_found", found, 1'b1);
    // Tap 0 of tile 5 was consumed the cycle before; STORE beat 0 comes 28 cycles later.
    repeat (28) @(negedge clk);
    check("pre_abort_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_outs", {busy, done, w_en, w_addr, fm_en, fm_addr, bias_en, bias_addr,
                         acc_clr, acc_en, out_we, out_addr}, 0);
    check("abort_din", out_din, 0);
    repeat (2) begin @(negedge clk); wr += int'(out_we); end
    rst = 1'b1;
    repeat (6) begin @(negedge clk); wr += int'(out_we); bz += int'(busy); end
    check("abort_no_write", wr, 0);
    check("abort_idle", bz, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (w_en) got = 1;
    end
    check("restart_w_en", got, 1'b1);
    check("restart_addr", {w_addr, fm_en, fm_addr, bias_addr}, {12'd0, 1'b1, 5'd0, 7'd0});
    do_reset();
  endtask

  task automatic small_test();
    int exp_addr [8] = '{0, 4, 1, 5, 2, 6, 3, 7};
    int cyc = 0, busy_cyc = -1, done_cyc = -1, n_wr = 0;
    relu_en = 1'b1;
    rst2 = 1'b1;
    @(negedge clk);
    start2 = 1'b1;
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start2 = 1'b0;
      if (s_busy && busy_cyc < 0) busy_cyc = cyc;
      if (s_out_we) begin
        if (n_wr < 8) check("small_addr", s_out_addr, 7'(exp_addr[n_wr]));
        check("small_din", s_out_din, exp_word(1'b1, n_wr % 2));
        n_wr++;
      end
      if (s_done) done_cyc = cyc;
    end
    check("small_done_seen", (done_cyc >= 0), 1'b1);
    check("small_latency", done_cyc - busy_cyc, 52);
    check("small_writes", n_wr, 8);
  endtask

  initial begin
    tbl[0]  = {17'h0FFFF, 16'h7FFF, 16'h7FFF};
    tbl[1]  = {17'h1FFFF, 16'h0000, 16'h0000};
    tbl[2]  = {17'h1FFFD, 16'hFFFF, 16'h0000};
    tbl[3]  = {17'h00000, 16'h0000, 16'h0000};
    tbl[4]  = {17'h00001, 16'h0001, 16'h0001};
    tbl[5]  = {17'h00002, 16'h0001, 16'h0001};
    tbl[6]  = {17'h00003, 16'h0002, 16'h0002};
    tbl[7]  = {17'h0FFFE, 16'h7FFF, 16'h7FFF};
    tbl[8]  = {17'h0FFFD, 16'h7FFF, 16'h7FFF};
    tbl[9]  = {17'h10000, 16'h8000, 16'h0000};
    tbl[10] = {17'h10001, 16'h8001, 16'h0000};
    tbl[11] = {17'h1FFFE, 16'hFFFF, 16'h0000};
    tbl[12] = {17'h00100, 16'h0080, 16'h0080};
    tbl[13] = {17'h1FF00, 16'hFF80, 16'h0000};
    tbl[14] = {17'h12345, 16'h91A3, 16'h0000};
    tbl[15] = {17'h05555, 16'h2AAB, 16'h2AAB};
    acc_data = '0;
    for (int h = 0; h < 2; h++) begin
      for (int l = 0; l < LANES; l++) begin
        acc_data[(h*LANES + l)*17 +: 17] = tbl[(l + 7*h) % 16].a;
      end
    end
    rst = 1'b0; rst2 = 1'b0; start = 1'b0; start2 = 1'b0; stall = 1'b0; stall2 = 1'b0;
    relu_en = 1'b0;
    #1;
    check("reset_outs", {busy, done, w_en, w_addr, fm_en, fm_addr, bias_en, bias_addr,
                         acc_clr, acc_en, out_we, out_addr}, 0);
    check("reset_din", out_din, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    run_layer(1'b0, 1'b0, 1'b0, 651);
    @(negedge clk);
    check("idle_after_done", {busy, done, out_we}, 3'b000);

    run_layer(1'b1, 1'b1, 1'b0, 661);
    @(negedge clk);

    run_layer(1'b0, 1'b0, 1'b1, 651);
    @(negedge clk);
    check("held_start_idle", busy, 1'b0);
    @(negedge clk);
    check("held_start_relaunch", busy, 1'b1);
    start = 1'b0;
    do_reset();

    abort_test();
    small_test();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
